mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback driver. It sits directly upstream of the register file write channel.
- Captures MEM-stage results and waits for load data from the data-bus response, which returns one or more cycles after the request.
- Aligns and extends load data, then issues exactly one write (we/waddr/wdata) per retiring instruction.
- Raises a stall request while a load in WB still lacks its data.

Parameters:
DATA_W, 32, datapath width (only 32 supported)
REG_AW, 5, register address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
stall  in  1  pipeline-control hold; the WB slot must not accept a new instruction
flush  in  1  squash the instruction currently presented by MEM (it is captured as a bubble)
mem_valid  in  1  MEM presents an instruction
mem_we  in  1  instruction writes a GPR
mem_waddr  in  5  destination GPR
mem_wdata  in  32  ALU/move result for non-loads
mem_is_load  in  1  instruction is a load
mem_load_type  in  3  0=LW 1=LB 2=LBU 3=LH 4=LHU; 5-7 treated as LW
mem_addr_lo  in  2  effective address bits [1:0]
dresp_valid  in  1  data-bus read response valid (single-cycle pulse)
dresp_rdata  in  32  data-bus read data, little-endian lanes
wb_we  out  1  regfile write enable
wb_waddr  out  5  regfile write address (zero-extended to the regfile address width at top level)
wb_wdata  out  32  regfile write data
wb_valid  out  1  WB slot holds a live instruction
wb_stall_req  out  1  WB is waiting for load data

Behaviour:
- Reset (rst=1 at posedge):
  - Slot valid, written flag, load buffer valid and all registered fields clear to 0.
  - Outputs after reset: wb_we=0, wb_waddr=0, wb_wdata=0, wb_valid=0, wb_stall_req=0.
  - rst overrides every other input. A load waiting mid-flight is dropped, not written.
- Slot state per instruction: EMPTY -> PEND (awaiting write) -> DONE (written, waiting to leave).
  - Loads in PEND additionally track HAVE_DATA (response captured into the internal buffer).
- wb_stall_req (combinational) = valid & is_load & !buf_valid & !dresp_valid.
- Capture condition cap = !stall & !wb_stall_req.
  - On cap, the slot loads the MEM fields.
  - valid_next = mem_valid & !flush.
  - The written flag and buf_valid clear.
  - If !cap, the slot holds all fields.
- Write (combinational):
  - ready = !is_load | buf_valid | dresp_valid.
  - wb_we = valid & we & (waddr!=0) & !written & ready.
  - On a cycle with wb_we=1, written is set at the next edge. Exactly one write per instruction, even if the slot is held many cycles by stall.
- Write data:
  - Non-load: the latched mem_wdata.
  - Load: src = dresp_rdata if dresp_valid & !buf_valid, else the buffer.
  - Byte lane = src[8*lo+7 : 8*lo]. Half lane = src[31:16] if lo[1], else src[15:0]; lo[0] is ignored for halves (alignment is checked in MEM).
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes src through.
- Load response while the slot is held:
  - A dresp_valid arriving while the slot holds a load with !buf_valid is captured into the buffer (buf_valid=1), even if stall=1.
  - Later cycles use the buffer; no response is ever lost.
- Ignored responses: a dresp_valid arriving when the slot is EMPTY, a non-load, or a load with buf_valid=1 is ignored.
- wb_waddr and wb_wdata are valid only when wb_we=1. Otherwise they hold the slot's waddr and the last computed data (don't-care for the regfile).
- flush and stall together: stall wins. The slot holds, and the squashed MEM instruction is re-presented or removed by upstream control.
- Zero-latency case: a load whose response arrives in its first WB cycle writes that cycle. wb_stall_req stays 0 throughout.
- Throughput: one instruction per cycle when no load waits.

Test Plan:
- Reset, then back-to-back ALU ops (r3<=0x11, r4<=0x22), no stall -> wb_we=1 on consecutive cycles with those addr/data; wb_stall_req=0.
- Load cases, dresp_rdata=0x8899AABB, mem_addr_lo=1:
  - LB -> wb_wdata=0xFFFFFFAA.
  - LBU -> 0x000000AA.
  - LH with lo=2 -> 0xFFFF8899.
  - LHU with lo=2 -> 0x00008899.
  - LW -> 0x8899AABB.
- LW to r5 with response delayed 3 cycles -> wb_stall_req=1 for 3 cycles, wb_we=0; on the response cycle wb_we=1, wb_wdata=response, wb_stall_req=0; next MEM instruction captured the following edge.
- ALU write to r6, then stall held 4 cycles -> wb_we high only in the first cycle; no duplicate write. Load response arriving during stall -> buffered, written once, correct data after stall drops.
- mem_we=1 with mem_waddr=0, and a flush on capture -> wb_we never asserts; wb_valid=0 for the flushed slot.
- rst asserted mid load-wait, then a stray dresp_valid -> all outputs 0; the stray response is ignored; the next ALU instruction writes normally.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and regfile writeback driver.
// Holds one instruction, waits for load data when needed and issues exactly one write per instruction.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_is_load,
    input  logic [2:0]        mem_load_type,
    input  logic [1:0]        mem_addr_lo,
    input  logic              dresp_valid,
    input  logic [DATA_W-1:0] dresp_rdata,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_valid,
    output logic              wb_stall_req
);

    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    logic              valid_q,     valid_d;
    logic              we_q,        we_d;
    logic [REG_AW-1:0] waddr_q,     waddr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              is_load_q,   is_load_d;
    logic [2:0]        ltype_q,     ltype_d;
    logic [1:0]        lo_q,        lo_d;
    logic              written_q,   written_d;
    logic              buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0] buf_q,       buf_d;

    logic              cap;
    logic              ready;
    logic [DATA_W-1:0] load_src;
    logic [DATA_W-1:0] load_data;

    // Lane select and extension; loads of type 0 and 5-7 behave as LW.
    function automatic logic [DATA_W-1:0] align_load(
        input logic [2:0]        ltype,
        input logic [1:0]        lo,
        input logic [DATA_W-1:0] src
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = src[7:0];
            2'd1:    b = src[15:8];
            2'd2:    b = src[23:16];
            default: b = src[31:24];
        endcase
        h = lo[1] ? src[31:16] : src[15:0];
        case (ltype)
            LT_LB:   align_load = {{(DATA_W-8){b[7]}}, b};
            LT_LBU:  align_load = {{(DATA_W-8){1'b0}}, b};
            LT_LH:   align_load = {{(DATA_W-16){h[15]}}, h};
            LT_LHU:  align_load = {{(DATA_W-16){1'b0}}, h};
            default: align_load = src;
        endcase
    endfunction

    always_comb begin
        wb_stall_req = valid_q & is_load_q & ~buf_valid_q & ~dresp_valid;
        cap          = ~stall & ~wb_stall_req;
        ready        = ~is_load_q | buf_valid_q | dresp_valid;
        wb_we        = valid_q & we_q & (waddr_q != '0) & ~written_q & ready;
        load_src     = (dresp_valid & ~buf_valid_q) ? dresp_rdata : buf_q;
        load_data    = align_load(ltype_q, lo_q, load_src);
        wb_wdata     = is_load_q ? load_data : wdata_q;
        wb_waddr     = waddr_q;
        wb_valid     = valid_q;
    end

    always_comb begin
        valid_d     = valid_q;
        we_d        = we_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        is_load_d   = is_load_q;
        ltype_d     = ltype_q;
        lo_d        = lo_q;
        written_d   = written_q;
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        if (cap) begin
            valid_d     = mem_valid & ~flush;
            we_d        = mem_we;
            waddr_d     = mem_waddr;
            wdata_d     = mem_wdata;
            is_load_d   = mem_is_load;
            ltype_d     = mem_load_type;
            lo_d        = mem_addr_lo;
            written_d   = 1'b0;
            buf_valid_d = 1'b0;
        end else begin
            if (wb_we)
                written_d = 1'b1;
            // Keep a response that arrives while the slot is held so it is never lost.
            if (valid_q & is_load_q & ~buf_valid_q & dresp_valid) begin
                buf_valid_d = 1'b1;
                buf_d       = dresp_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            is_load_q   <= 1'b0;
            ltype_q     <= '0;
            lo_q        <= '0;
            written_q   <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            is_load_q   <= is_load_d;
            ltype_q     <= ltype_d;
            lo_q        <= lo_d;
            written_q   <= written_d;
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboarded bench for mem_wb_stage: expected regfile writes are queued as stimulus is driven
// and matched against every wb_we pulse; scenario tasks add inline checks on stall/valid behaviour.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        mem_valid, mem_we, mem_is_load;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_addr_lo;
    logic        dresp_valid;
    logic [31:0] dresp_rdata;
    logic        wb_we, wb_valid, wb_stall_req;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [4:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_is_load(mem_is_load),
        .mem_load_type(mem_load_type), .mem_addr_lo(mem_addr_lo),
        .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_valid(wb_valid), .wb_stall_req(wb_stall_req)
    );

    always #5 clk = ~clk;

    // Every write the DUT issues must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wb_we === 1'b1) begin
            n_tests++;
            if (exp_addr_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write: got addr=%0d data=%h, expected no write", wb_waddr, wb_wdata);
            end else begin
                logic [4:0]  ea;
                logic [31:0] ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (wb_waddr !== ea || wb_wdata !== ed) begin
                    n_fail++;
                    $display("FAIL sb_write: got addr=%0d data=%h, expected addr=%0d data=%h", wb_waddr, wb_wdata, ea, ed);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_mem();
        mem_valid = 0; mem_we = 0; mem_waddr = 0; mem_wdata = 0;
        mem_is_load = 0; mem_load_type = 0; mem_addr_lo = 0;
    endtask

    task automatic drive_alu(input logic [4:0] a, input logic [31:0] d, input bit expect_wr);
        mem_valid = 1; mem_we = 1; mem_waddr = a; mem_wdata = d;
        mem_is_load = 0; mem_load_type = 0; mem_addr_lo = 0;
        if (expect_wr) begin
            exp_addr_q.push_back(a);
            exp_data_q.push_back(d);
        end
    endtask

    task automatic drive_load(input logic [4:0] a, input logic [2:0] t, input logic [1:0] lo,
                              input logic [31:0] exp_d);
        mem_valid = 1; mem_we = 1; mem_waddr = a; mem_wdata = 32'h5A5A5A5A;
        mem_is_load = 1; mem_load_type = t; mem_addr_lo = lo;
        exp_addr_q.push_back(a);
        exp_data_q.push_back(exp_d);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1; stall = 0; flush = 0; dresp_valid = 0; dresp_rdata = 0;
        idle_mem();
        tick(); tick();
        rst = 0;
        @(negedge clk);
        n_tests++;
        if ({wb_we, wb_valid, wb_stall_req} !== 3'b000 || wb_waddr !== 5'd0 || wb_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b valid=%b stall_req=%b addr=%0d data=%h, expected all 0",
                     wb_we, wb_valid, wb_stall_req, wb_waddr, wb_wdata);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        drive_alu(5'd3, 32'h11, 1);
        tick();
        drive_alu(5'd4, 32'h22, 1);
        @(negedge clk);
        chk("b2b_we_first", {31'd0, wb_we}, 32'd1);
        chk("b2b_stall_first", {31'd0, wb_stall_req}, 32'd0);
        tick();
        idle_mem();
        @(negedge clk);
        chk("b2b_we_second", {31'd0, wb_we}, 32'd1);
        chk("b2b_addr_second", {27'd0, wb_waddr}, 32'd4);
    endtask

    task automatic test_load_align();
        logic [2:0]  types[5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        logic [1:0]  los[5]   = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1};
        logic [31:0] exps[5]  = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'h8899AABB};
        for (int i = 0; i < 5; i++) begin
            tick();
            drive_load(5'd7, types[i], los[i], exps[i]);
            dresp_valid = 0;
            tick();
            idle_mem();
            dresp_valid = 1; dresp_rdata = 32'h8899AABB;
            @(negedge clk);
            chk($sformatf("load%0d_we", i), {31'd0, wb_we}, 32'd1);
            chk($sformatf("load%0d_stall", i), {31'd0, wb_stall_req}, 32'd0);
            tick();
            dresp_valid = 0;
        end
    endtask

    task automatic test_load_latency();
        int stall_cycles = 0;
        drive_load(5'd5, 3'd0, 2'd0, 32'hCAFE0005);
        tick();
        drive_alu(5'd8, 32'h88, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (wb_stall_req === 1'b1 && wb_we === 1'b0) stall_cycles++;
            tick();
        end
        chk("lat_stall_cycles", stall_cycles, 32'd3);
        dresp_valid = 1; dresp_rdata = 32'hCAFE0005;
        @(negedge clk);
        chk("lat_we_on_resp", {31'd0, wb_we}, 32'd1);
        chk("lat_stall_on_resp", {31'd0, wb_stall_req}, 32'd0);
        tick();
        idle_mem();
        dresp_valid = 0;
        @(negedge clk);
        chk("lat_next_captured", {27'd0, wb_waddr}, 32'd8);
        chk("lat_next_we", {31'd0, wb_we}, 32'd1);
        tick();
    endtask

    task automatic test_stall_hold();
        int writes = 0;
        drive_alu(5'd6, 32'h66, 1);
        tick();
        drive_alu(5'd9, 32'h99, 1);
        stall = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (wb_we === 1'b1) writes++;
            tick();
        end
        chk("stall_single_write", writes, 32'd1);
        stall = 0;
        @(negedge clk);
        chk("stall_release_no_dup", {31'd0, wb_we}, 32'd0);
        tick();
        drive_load(5'd10, 3'd4, 2'd0, 32'h0000F00D);
        @(negedge clk);
        chk("stall_r9_written", {27'd0, wb_waddr}, 32'd9);
        tick();
        idle_mem();
        stall = 1;
        @(negedge clk);
        chk("stall_load_wait", {31'd0, wb_stall_req}, 32'd1);
        tick();
        dresp_valid = 1; dresp_rdata = 32'h1234F00D;
        @(negedge clk);
        chk("stall_load_we_resp", {31'd0, wb_we}, 32'd1);
        tick();
        dresp_valid = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("stall_buf_no_stall%0d", c), {31'd0, wb_stall_req}, 32'd0);
            tick();
        end
        stall = 0;
        dresp_valid = 1; dresp_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("stall_stray_ignored", {31'd0, wb_we}, 32'd0);
        tick();
        dresp_valid = 0;
    endtask

    task automatic test_no_write();
        drive_alu(5'd0, 32'hDEAD, 0);
        tick();
        drive_alu(5'd11, 32'hBEEF, 0);
        flush = 1;
        @(negedge clk);
        chk("r0_valid", {31'd0, wb_valid}, 32'd1);
        chk("r0_no_we", {31'd0, wb_we}, 32'd0);
        tick();
        idle_mem();
        flush = 0;
        @(negedge clk);
        chk("flush_valid", {31'd0, wb_valid}, 32'd0);
        chk("flush_no_we", {31'd0, wb_we}, 32'd0);
        tick();
    endtask

    task automatic test_reset_mid_load();
        mem_valid = 1; mem_we = 1; mem_waddr = 5'd12; mem_wdata = 0;
        mem_is_load = 1; mem_load_type = 0; mem_addr_lo = 0;
        tick();
        idle_mem();
        @(negedge clk);
        chk("rml_waiting", {31'd0, wb_stall_req}, 32'd1);
        rst = 1;
        tick();
        rst = 0;
        dresp_valid = 1; dresp_rdata = 32'h77777777;
        @(negedge clk);
        n_tests++;
        if ({wb_we, wb_valid, wb_stall_req} !== 3'b000 || wb_waddr !== 5'd0 || wb_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rml_outputs: got we=%b valid=%b stall_req=%b addr=%0d data=%h, expected all 0",
                     wb_we, wb_valid, wb_stall_req, wb_waddr, wb_wdata);
        end
        tick();
        dresp_valid = 0;
        drive_alu(5'd13, 32'h1313, 1);
        tick();
        idle_mem();
        @(negedge clk);
        chk("rml_alu_we", {31'd0, wb_we}, 32'd1);
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_align();
        test_load_latency();
        test_stall_hold();
        test_no_write();
        test_reset_mid_load();
        for (int c = 0; c < 20 && exp_addr_q.size() != 0; c++) tick();
        n_tests++;
        if (exp_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d writes outstanding, expected 0", exp_addr_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
